matmul_apb_regif: RTL and testbench
===================================

MATMUL_APB_REGIF -- requirements
Module: matmul_apb_regif

Interface
REQ-001 Parameter DATA_WIDTH, 8, element width (8/16/32); MAX_DIM = BUS_WIDTH/DATA_WIDTH, capped at 4; NE = MAX_DIM*MAX_DIM.
REQ-002 Parameter BUS_WIDTH, 32, APB data width (16/32/64).
REQ-003 Parameter ADDR_WIDTH, 16, APB address width (16/24/32).
REQ-004 Parameter SP_NTARGETS, 4, scratchpad targets (1/2/4).
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-008 paddr_i  in  ADDR_WIDTH; pwdata_i  in  BUS_WIDTH; pstrb_i  in  BUS_WIDTH/8; byte strobes.
REQ-009 prdata_o  out  BUS_WIDTH; pready_o  out  1; pslverr_o  out  1.
REQ-010 mem_we_o  out  1; mem_sel_o  out  3 (1=A, 2=B, 4..7=SP target); mem_idx_o  out  4; mem_wdata_o  out  BUS_WIDTH; mem_strb_o  out  BUS_WIDTH/8.
REQ-011 mem_re_o  out  1; mem_rdata_i  in  BUS_WIDTH, valid the cycle after mem_re_o.
REQ-012 start_o  out  1 (one-cycle pulse); busy_o  out  1; ctrl_o  out  16.
REQ-013 eop_i  in  1; result_i  in  BUS_WIDTH*NE, element k = bits [(k+1)*BUS_WIDTH-1 : k*BUS_WIDTH]; ov_i  in  NE.

Function
REQ-014 Decode: region = paddr_i[8:6], idx = paddr_i[5:2]; region 0 CTRL, 1 OPA, 2 OPB, 3 FLAGS, 4+t SP target t.
REQ-015 FSM states: IDLE, ACCESS, RD_WAIT, BUSY, WRITEBACK; transitions only on clk_i rising edge.
REQ-016 IDLE -> ACCESS when psel_i=1 and penable_i=0.
REQ-017 ACCESS write: pready_o=1 in the same cycle (zero wait states); CTRL/OPA/OPB updated byte-wise per pstrb_i; next state IDLE, or BUSY when CTRL bit0 is written 1.
REQ-018 ACCESS read of OPA/OPB/SP: mem_re_o=1 and pready_o=0 -> RD_WAIT; RD_WAIT: pready_o=1, prdata_o=mem_rdata_i -> IDLE (exactly one wait state).
REQ-019 ACCESS read of CTRL/FLAGS: pready_o=1, zero wait states; unused prdata_o bits are 0.
REQ-020 pslverr_o=1 with pready_o in these cases: write to FLAGS or SP; SP target >= SP_NTARGETS; idx >= MAX_DIM for OPA/OPB; idx >= NE for SP. An errored access has no side effect.
REQ-021 CTRL bits: [0] start, [3:2] SP write target, [5:4] SP read target, [6] irq enable, [15:7] held, reported on ctrl_o; bit0 self-clears at end of WRITEBACK.
REQ-022 Entering BUSY: start_o pulses 1 cycle, busy_o=1 from the next edge.
REQ-023 BUSY: any APB access completes with pready_o=1 in ACCESS, pslverr_o=1 and no effect, except CTRL/FLAGS reads, which succeed; state remains BUSY.
REQ-024 BUSY -> WRITEBACK on eop_i=1; eop_i outside BUSY is ignored.
REQ-025 WRITEBACK: for k=0..NE-1 on consecutive cycles, mem_we_o=1, mem_sel_o=4+CTRL[3:2], mem_idx_o=k, mem_wdata_o=element k, mem_strb_o all ones.
REQ-026 After element NE-1: FLAGS<=ov_i, CTRL[0]<=0, busy_o<=0, state IDLE; total length NE cycles.
REQ-027 Other accesses during WRITEBACK are treated as in REQ-023; APB wait is never inserted for them.
REQ-028 mem_we_o and mem_re_o are never asserted in the same cycle.

Reset
REQ-029 Asynchronous assertion: state IDLE; CTRL, FLAGS, prdata_o, write counter = 0; pready_o, pslverr_o, start_o, busy_o, mem_we_o, mem_re_o = 0.
REQ-030 Reset mid-BUSY/WRITEBACK aborts; partial SP contents are not restored; FLAGS=0.
REQ-031 Release is synchronous to clk_i; first APB setup is accepted on the first edge after release.

Configuration
REQ-032 Macro MATMUL_REGIF_IRQ_EN.
- Defined: output irq_o (1 bit) sets on WRITEBACK completion when CTRL[6]=1; a successful FLAGS read clears it; if set and clear coincide, set wins.
- Undefined: irq_o port absent; CTRL[6] is storage only.

Verification (DATA_WIDTH=8, BUS_WIDTH=32, NE=16)
REQ-033 Write OPA idx 2, pwdata=0xAABBCCDD, pstrb=0b0101 -> mem_we_o one cycle, sel=1, idx=2, strb=0101, pready same cycle, pslverr=0.
REQ-034 Read SP target 1 idx 5, mem_rdata_i=0x12345678 -> pready low 1 cycle then high, prdata=0x12345678.
REQ-035 Write CTRL=0x0005 -> start_o pulse and busy_o=1; eop_i pulse -> 16 writes sel=5, idx 0..15; then FLAGS=ov_i=0x8001 and CTRL reads 0x0004.
REQ-036 While busy, write OPB -> pslverr=1, no mem_we_o; read CTRL -> pslverr=0, data 0x0005.
REQ-037 SP_NTARGETS=2, read region 7 -> pslverr=1; write OPA idx 4 -> pslverr=1.
REQ-038 rst_n_i low during WRITEBACK at k=7 -> all outputs return to reset values immediately; the next CTRL read returns 0.

Source files
------------

// File: rtl/matmul_apb_regif_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_apb_regif_if
// Purpose  : APB completer-side bus bundle for the matmul register interface.
//            Carries the APB request (select, enable, direction, address,
//            data, byte strobes) and the response (read data, ready, error).
// Revision : 1.0 - initial release
// ============================================================================
interface matmul_apb_regif_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 32
);
    logic                   psel_i;
    logic                   penable_i;
    logic                   pwrite_i;
    logic [ADDR_WIDTH-1:0]  paddr_i;
    logic [BUS_WIDTH-1:0]   pwdata_i;
    logic [BUS_WIDTH/8-1:0] pstrb_i;
    logic [BUS_WIDTH-1:0]   prdata_o;
    logic                   pready_o;
    logic                   pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface
`default_nettype wire

// File: rtl/matmul_apb_regif.sv
`default_nettype none
// ============================================================================
// Module   : matmul_apb_regif
// Purpose  : APB register front-end of the matrix-multiply engine. Decodes
//            CTRL / OPA / OPB / FLAGS / scratchpad regions, forwards operand
//            and scratchpad accesses to the memory port, launches the engine
//            and streams its result matrix into the selected scratchpad.
// Options  : define MATMUL_REGIF_IRQ_EN to add the irq_o completion interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_apb_regif #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int BUS_WIDTH   = 32,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int SP_NTARGETS = 4,
    localparam int MAX_DIM     = ((BUS_WIDTH / DATA_WIDTH) > 4) ? 4 : (BUS_WIDTH / DATA_WIDTH),
    localparam int NE          = MAX_DIM * MAX_DIM,
    localparam int NSTRB       = BUS_WIDTH / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    matmul_apb_regif_if.slave       apb,
    output logic                    mem_we_o,
    output logic [2:0]              mem_sel_o,
    output logic [3:0]              mem_idx_o,
    output logic [BUS_WIDTH-1:0]    mem_wdata_o,
    output logic [NSTRB-1:0]        mem_strb_o,
    output logic                    mem_re_o,
    input  logic [BUS_WIDTH-1:0]    mem_rdata_i,
    output logic                    start_o,
    output logic                    busy_o,
    output logic [15:0]             ctrl_o,
    input  logic                    eop_i,
    input  logic [BUS_WIDTH*NE-1:0] result_i,
    input  logic [NE-1:0]           ov_i
`ifdef MATMUL_REGIF_IRQ_EN
    ,
    output logic                    irq_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACCESS    = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_BUSY      = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_ctrl;
    logic [NE-1:0]        r_flags;
    logic [3:0]           r_wb_cnt;
    logic                 r_start;
    logic                 r_busy;

    logic [2:0]           w_region;
    logic [3:0]           w_idx;
    logic [1:0]           w_sp_tgt;
    logic                 w_is_ctrl, w_is_opa, w_is_opb, w_is_flags, w_is_sp;
    logic                 w_addr_bad, w_acc_err, w_busy_rd_ok;
    logic                 w_ctrl_wr, w_start_req, w_wb_last;
    logic [BUS_WIDTH-1:0] w_reg_rdata;
    logic                 w_unused_addr;

    // Address decode: region in [8:6], word index in [5:2].
    assign w_region      = apb.paddr_i[8:6];
    assign w_idx         = apb.paddr_i[5:2];
    assign w_sp_tgt      = w_region[1:0];
    assign w_unused_addr = ^{apb.paddr_i[ADDR_WIDTH-1:9], apb.paddr_i[1:0]};

    assign w_is_ctrl  = (w_region == 3'd0);
    assign w_is_opa   = (w_region == 3'd1);
    assign w_is_opb   = (w_region == 3'd2);
    assign w_is_flags = (w_region == 3'd3);
    assign w_is_sp    = w_region[2];

    assign w_addr_bad = ((w_is_opa || w_is_opb) && (32'(w_idx) >= MAX_DIM))
                      || (w_is_sp && ((32'(w_sp_tgt) >= SP_NTARGETS) || (32'(w_idx) >= NE)));
    assign w_acc_err  = w_addr_bad || (apb.pwrite_i && (w_is_flags || w_is_sp));

    // While the engine runs only CTRL/FLAGS reads are honoured.
    assign w_busy_rd_ok = !apb.pwrite_i && (w_is_ctrl || w_is_flags);

    assign w_ctrl_wr   = (r_state == S_ACCESS) && apb.pwrite_i && w_is_ctrl && !w_acc_err;
    assign w_start_req = (r_state == S_ACCESS) && (w_state_nxt == S_BUSY);
    assign w_wb_last   = (r_state == S_WRITEBACK) && (r_wb_cnt == 4'(NE - 1));

    assign start_o = r_start;
    assign busy_o  = r_busy;
    assign ctrl_o  = r_ctrl;

    // Register read mux for the zero-wait-state regions; upper bits stay zero.
    always_comb begin
        w_reg_rdata = '0;
        if (w_is_ctrl) w_reg_rdata[15:0]   = r_ctrl;
        else           w_reg_rdata[NE-1:0] = r_flags;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic together with APB response and memory-port drive.
    always_comb begin
        w_state_nxt   = r_state;
        apb.pready_o  = 1'b0;
        apb.pslverr_o = 1'b0;
        apb.prdata_o  = '0;
        mem_we_o      = 1'b0;
        mem_re_o      = 1'b0;
        mem_sel_o     = 3'd0;
        mem_idx_o     = 4'd0;
        mem_wdata_o   = '0;
        mem_strb_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (apb.psel_i && !apb.penable_i) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                apb.pready_o = 1'b1;
                w_state_nxt  = S_IDLE;
                if (w_acc_err) begin
                    apb.pslverr_o = 1'b1;
                end else if (apb.pwrite_i) begin
                    if (w_is_opa || w_is_opb) begin
                        // Region number doubles as the memory select code.
                        mem_we_o    = 1'b1;
                        mem_sel_o   = w_region;
                        mem_idx_o   = w_idx;
                        mem_wdata_o = apb.pwdata_i;
                        mem_strb_o  = apb.pstrb_i;
                    end
                    if (w_is_ctrl && apb.pstrb_i[0] && apb.pwdata_i[0]) w_state_nxt = S_BUSY;
                end else if (w_is_ctrl || w_is_flags) begin
                    apb.prdata_o = w_reg_rdata;
                end else begin
                    // Memory-backed read: one wait state for the read data.
                    apb.pready_o = 1'b0;
                    mem_re_o     = 1'b1;
                    mem_sel_o    = w_region;
                    mem_idx_o    = w_idx;
                    w_state_nxt  = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                apb.pready_o = 1'b1;
                apb.prdata_o = mem_rdata_i;
                w_state_nxt  = S_IDLE;
            end
            S_BUSY, S_WRITEBACK: begin
                if (apb.psel_i && apb.penable_i) begin
                    apb.pready_o = 1'b1;
                    if (w_busy_rd_ok) apb.prdata_o  = w_reg_rdata;
                    else              apb.pslverr_o = 1'b1;
                end
                if (r_state == S_BUSY) begin
                    if (eop_i) w_state_nxt = S_WRITEBACK;
                end else begin
                    mem_we_o    = 1'b1;
                    mem_sel_o   = {1'b1, r_ctrl[3:2]};
                    mem_idx_o   = r_wb_cnt;
                    mem_wdata_o = result_i[int'(r_wb_cnt)*BUS_WIDTH +: BUS_WIDTH];
                    mem_strb_o  = '1;
                    // A setup phase landing on the last beat must not be lost.
                    if (w_wb_last) w_state_nxt = (apb.psel_i && !apb.penable_i) ? S_ACCESS : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // CTRL/FLAGS storage, start/busy status and the writeback beat counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl   <= '0;
            r_flags  <= '0;
            r_wb_cnt <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_start <= w_start_req;
            if (w_start_req)    r_busy <= 1'b1;
            else if (w_wb_last) r_busy <= 1'b0;
            if (w_ctrl_wr) begin
                if (apb.pstrb_i[0]) r_ctrl[7:0]  <= apb.pwdata_i[7:0];
                if (apb.pstrb_i[1]) r_ctrl[15:8] <= apb.pwdata_i[15:8];
            end
            if (w_wb_last) begin
                r_flags   <= ov_i;
                r_ctrl[0] <= 1'b0;
            end
            if (r_state == S_WRITEBACK) r_wb_cnt <= w_wb_last ? 4'd0 : r_wb_cnt + 4'd1;
        end
    end

`ifdef MATMUL_REGIF_IRQ_EN
    logic r_irq;
    logic w_flag_rd;

    assign w_flag_rd = apb.pready_o && !apb.pslverr_o && !apb.pwrite_i && w_is_flags;
    assign irq_o     = r_irq;

    // Completion interrupt: set on writeback end when enabled, set beats clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                  r_irq <= 1'b0;
        else if (w_wb_last && r_ctrl[6]) r_irq <= 1'b1;
        else if (w_flag_rd)            r_irq <= 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_apb_regif
// Purpose  : Scoreboard bench for matmul_apb_regif (DATA_WIDTH=8,
//            BUS_WIDTH=32, SP_NTARGETS=2). A register-level model predicts
//            APB responses and memory-port events; a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_apb_regif;
    localparam int DW  = 8;
    localparam int BW  = 32;
    localparam int AW  = 16;
    localparam int SPN = 2;
    localparam int NE  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_apb_regif_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) apb ();

    logic           mem_we, mem_re, start, busy, eop;
    logic [2:0]     mem_sel;
    logic [3:0]     mem_idx, mem_strb;
    logic [31:0]    mem_wdata, mem_rdata;
    logic [15:0]    ctrl, ov;
    logic [BW*NE-1:0] result;
`ifdef MATMUL_REGIF_IRQ_EN
    logic           irq;
`endif

    matmul_apb_regif #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .SP_NTARGETS(SPN)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .apb        (apb),
        .mem_we_o   (mem_we),
        .mem_sel_o  (mem_sel),
        .mem_idx_o  (mem_idx),
        .mem_wdata_o(mem_wdata),
        .mem_strb_o (mem_strb),
        .mem_re_o   (mem_re),
        .mem_rdata_i(mem_rdata),
        .start_o    (start),
        .busy_o     (busy),
        .ctrl_o     (ctrl),
        .eop_i      (eop),
        .result_i   (result),
        .ov_i       (ov)
`ifdef MATMUL_REGIF_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
    } apb_exp_t;

    typedef struct {
        bit          we;
        logic [2:0]  sel;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mem_exp_t;

    apb_exp_t    apb_q[$];
    mem_exp_t    mem_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rsp      = 32'h0;

    // Reference model state: register contents and engine activity.
    logic [15:0] m_ctrl  = 16'h0;
    logic [15:0] m_flags = 16'h0;
    bit          m_busy  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Memory model: returns the prepared response the cycle after a read strobe.
    always @(posedge clk) mem_rdata <= mem_re ? rsp : 32'hDEAD_BEEF;

    // Monitor: pops and compares whenever the DUT completes an APB transfer
    // or presents a memory-port event.
    always @(negedge clk) begin
        apb_exp_t ea;
        mem_exp_t em;
        if (rst_n) begin
            if (apb.psel_i && apb.penable_i && apb.pready_o) begin
                if (apb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL apb_unexpected: got completion at 0x%0h, expected none", apb.paddr_i);
                end else begin
                    ea = apb_q.pop_front();
                    chk("pslverr", 64'(apb.pslverr_o), 64'(ea.err));
                    if (ea.rd && !ea.err) chk("prdata", 64'(apb.prdata_o), 64'(ea.data));
                end
            end
            if (mem_we || mem_re) begin
                chk("we_re_exclusive", 64'(mem_we & mem_re), 64'(0));
                if (mem_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL mem_unexpected: got we=%0b re=%0b sel=%0d idx=%0d, expected none",
                             mem_we, mem_re, mem_sel, mem_idx);
                end else begin
                    em = mem_q.pop_front();
                    chk("mem_kind_we", 64'(mem_we), 64'(em.we));
                    chk("mem_sel", 64'(mem_sel), 64'(em.sel));
                    chk("mem_idx", 64'(mem_idx), 64'(em.idx));
                    if (em.we) begin
                        chk("mem_wdata", 64'(mem_wdata), 64'(em.wdata));
                        chk("mem_strb", 64'(mem_strb), 64'(em.strb));
                    end
                end
            end
        end
    end

    // One APB transfer: predict from the model, queue expectations, drive.
    task automatic xfer(input bit wr, input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] st);
        apb_exp_t a;
        mem_exp_t m;
        int       region, idx, lat, n;
        bit       bad;
        region = int'(addr[8:6]);
        idx    = int'(addr[5:2]);
        a.rd   = !wr;
        a.err  = 1'b0;
        a.data = 32'h0;
        lat    = 1;
        if (m_busy) begin
            a.err  = !(!wr && (region == 0 || region == 3));
            a.data = (region == 0) ? {16'h0, m_ctrl} : {16'h0, m_flags};
        end else begin
            bad = ((region == 1 || region == 2) && idx >= 4)
               || (region >= 4 && (region - 4 >= SPN || idx >= NE))
               || (wr && region >= 3);
            if (bad) begin
                a.err = 1'b1;
            end else if (wr) begin
                if (region == 0) begin
                    if (st[0]) m_ctrl[7:0]  = wd[7:0];
                    if (st[1]) m_ctrl[15:8] = wd[15:8];
                    if (st[0] && wd[0]) m_busy = 1'b1;
                end else begin
                    m.we = 1'b1; m.sel = 3'(region); m.idx = 4'(idx); m.wdata = wd; m.strb = st;
                    mem_q.push_back(m);
                end
            end else if (region == 0 || region == 3) begin
                a.data = (region == 0) ? {16'h0, m_ctrl} : {16'h0, m_flags};
            end else begin
                rsp    = $urandom;
                a.data = rsp;
                lat    = 2;
                m.we = 1'b0; m.sel = 3'(region); m.idx = 4'(idx); m.wdata = 32'h0; m.strb = 4'h0;
                mem_q.push_back(m);
            end
        end
        apb_q.push_back(a);

        @(posedge clk); #1;
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = wr;
        apb.paddr_i   = {7'd0, addr};
        apb.pwdata_i  = wd;
        apb.pstrb_i   = st;
        @(posedge clk); #1;
        apb.penable_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!apb.pready_o && n < 8);
        chk("access_latency", 64'(n), 64'(lat));
        @(posedge clk); #1;
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
    endtask

    // Launch the engine's result stream; optionally reset at beat abort_at.
    task automatic run_wb(input logic [15:0] ov_val, input int abort_at);
        mem_exp_t m;
        int       n;
        for (int w = 0; w < NE; w++) result[w*32 +: 32] = $urandom;
        ov = ov_val;
        for (int k = 0; k < NE; k++) begin
            m.we = 1'b1; m.sel = 3'(4 + int'(m_ctrl[3:2])); m.idx = 4'(k);
            m.wdata = result[k*32 +: 32]; m.strb = 4'hF;
            mem_q.push_back(m);
        end
        @(posedge clk); #1; eop = 1'b1;
        @(posedge clk); #1; eop = 1'b0;
        if (abort_at < 0) begin
            xfer(1'b0, 9'h000, 32'h0, 4'h0);
            n = 0;
            while (busy && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("busy_release", 64'(busy), 64'(0));
            m_flags = ov_val;
            m_ctrl[0] = 1'b0;
            m_busy = 1'b0;
            chk("wb_all_beats", 64'(mem_q.size()), 64'(0));
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(mem_we && mem_idx == 4'(abort_at)) && n < 40);
            chk("wb_reach_abort", 64'({mem_we, mem_idx}), 64'({1'b1, 4'(abort_at)}));
            #1 rst_n = 1'b0;
            #1;
            chk("abort_mem_we", 64'(mem_we), 64'(0));
            chk("abort_mem_re", 64'(mem_re), 64'(0));
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_start", 64'(start), 64'(0));
            chk("abort_ctrl", 64'(ctrl), 64'(0));
            chk("abort_pready", 64'({apb.pready_o, apb.pslverr_o}), 64'(0));
            mem_q.delete();
            m_ctrl = 16'h0; m_flags = 16'h0; m_busy = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
        end
    endtask

    initial begin
        bit          r_wr;
        logic [2:0]  r_reg;
        logic [3:0]  r_ix, r_st;
        logic [31:0] r_wd;

        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
        apb.paddr_i = '0; apb.pwdata_i = '0; apb.pstrb_i = '0;
        eop = 1'b0; ov = 16'h0; result = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 64'(apb.pready_o), 64'(0));
        chk("rst_pslverr", 64'(apb.pslverr_o), 64'(0));
        chk("rst_prdata", 64'(apb.prdata_o), 64'(0));
        chk("rst_start_busy", 64'({start, busy}), 64'(0));
        chk("rst_mem_we_re", 64'({mem_we, mem_re}), 64'(0));
        chk("rst_ctrl", 64'(ctrl), 64'(0));
        rst_n = 1'b1;

        // Directed: operand write, scratchpad read, address-range errors.
        xfer(1'b1, 9'h048, 32'hAABB_CCDD, 4'b0101);
        xfer(1'b0, 9'h154, 32'h0, 4'h0);
        xfer(1'b0, 9'h1C0, 32'h0, 4'h0);
        xfer(1'b1, 9'h050, 32'h1234_5678, 4'hF);
        xfer(1'b0, 9'h0C0, 32'h0, 4'h0);

        // An end-of-operation pulse while idle must have no effect.
        @(posedge clk); #1 eop = 1'b1;
        @(posedge clk); #1 eop = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("eop_idle_ignored", 64'({busy, start}), 64'(0));

        // Randomized register traffic with the engine idle.
        for (int i = 0; i < 50; i++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_reg = 3'($urandom_range(0, 7));
            r_ix  = 4'($urandom);
            r_wd  = $urandom;
            r_st  = 4'($urandom);
            if (r_reg == 3'd0) r_wd[0] = 1'b0;
            xfer(r_wr, {r_reg, r_ix, 2'b00}, r_wd, r_st);
        end

        // Full run: start, accesses while busy, result writeback.
        xfer(1'b1, 9'h000, 32'h0000_0005, 4'b0011);
        chk("start_pulse", 64'(start), 64'(1));
        chk("busy_set", 64'(busy), 64'(1));
        @(posedge clk); #1;
        chk("start_single", 64'(start), 64'(0));
        chk("busy_hold", 64'(busy), 64'(1));
        xfer(1'b1, 9'h084, 32'hCAFE_F00D, 4'hF);
        xfer(1'b0, 9'h000, 32'h0, 4'h0);
        xfer(1'b0, 9'h0C0, 32'h0, 4'h0);
        xfer(1'b0, 9'h044, 32'h0, 4'h0);
        run_wb(16'h8001, -1);
        xfer(1'b0, 9'h0C0, 32'h0, 4'h0);
        xfer(1'b0, 9'h000, 32'h0, 4'h0);

        // Second run aborted by reset mid-writeback.
        xfer(1'b1, 9'h000, 32'h0000_0009, 4'b0001);
        run_wb(16'($urandom), 7);
        xfer(1'b0, 9'h000, 32'h0, 4'h0);
        xfer(1'b0, 9'h0C0, 32'h0, 4'h0);

        // Further random traffic after recovery.
        for (int i = 0; i < 20; i++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_reg = 3'($urandom_range(0, 7));
            r_ix  = 4'($urandom);
            r_wd  = $urandom;
            r_st  = 4'($urandom);
            if (r_reg == 3'd0) r_wd[0] = 1'b0;
            xfer(r_wr, {r_reg, r_ix, 2'b00}, r_wd, r_st);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("apb_q_drained", 64'(apb_q.size()), 64'(0));
        chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
